// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants, pooling FSM states and signed helpers for the CNN layers
package cnn_pkg;

    localparam int CNN_DATA_WIDTH   = 16;
    localparam int FIXED_POINT_BITS = 8;

    typedef enum logic [1:0] {
        POOL_IDLE,
        POOL_RUN,
        POOL_DONE
    } pool_state_e;

    function automatic logic signed [CNN_DATA_WIDTH-1:0] smax(
        input logic signed [CNN_DATA_WIDTH-1:0] a,
        input logic signed [CNN_DATA_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [CNN_DATA_WIDTH-1:0] relu(
        input logic signed [CNN_DATA_WIDTH-1:0] x
    );
        return x[CNN_DATA_WIDTH-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// rtl/pool_line_buffer.sv - one-row store of horizontal pair maxima, combinational read
module pool_line_buffer #(
    parameter int DEPTH = 31,
    parameter int WIDTH = 16,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are always rewritten on an even row before an odd row reads them.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/maxpool2d.sv
// rtl/maxpool2d.sv - 2x2 stride-2 max pooling with optional ReLU over a channel-major stream
module maxpool2d
    import cnn_pkg::*;
#(
    parameter int IN_WIDTH     = 62,
    parameter int IN_HEIGHT    = 62,
    parameter int NUM_CHANNELS = 30,
    parameter int DATA_WIDTH   = CNN_DATA_WIDTH,
    parameter int APPLY_RELU   = 1,
    localparam int OUT_W  = IN_WIDTH / 2,
    localparam int OUT_H  = IN_HEIGHT / 2,
    localparam int OUT_N  = OUT_W * OUT_H * NUM_CHANNELS,
    localparam int ADDR_W = (OUT_N > 1) ? $clog2(OUT_N) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_W-1:0]     out_addr,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  pool_done
);

    localparam int CW       = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int RW       = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int CHW      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int LB_DEPTH = (OUT_W > 0) ? OUT_W : 1;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam int PLANE    = OUT_W * OUT_H;

    localparam logic [CW-1:0]  C_LAST  = CW'(IN_WIDTH - 1);
    localparam logic [RW-1:0]  R_LAST  = RW'(IN_HEIGHT - 1);
    localparam logic [CHW-1:0] CH_LAST = CHW'(NUM_CHANNELS - 1);

    pool_state_e state_q, state_d;
    logic [CW-1:0]  c_q, c_d;
    logic [RW-1:0]  r_q, r_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic signed [DATA_WIDTH-1:0] hmax_q, hmax_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0]     out_addr_q, out_addr_d;
    logic out_valid_q, out_valid_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic last_c, last_r, last_ch, in_pool, accept, lb_we;
    logic [LB_AW-1:0] lb_addr;
    logic [DATA_WIDTH-1:0] lb_rd_raw;
    logic signed [DATA_WIDTH-1:0] x, pair, lb_rd, pool_max, res;
    logic [ADDR_W-1:0] addr_now;

    assign last_c  = (c_q == C_LAST);
    assign last_r  = (r_q == R_LAST);
    assign last_ch = (ch_q == CH_LAST);
    // An odd dimension leaves one trailing column/row that has no pooling partner.
    assign in_pool = !((IN_WIDTH % 2 == 1) && last_c) && !((IN_HEIGHT % 2 == 1) && last_r);
    assign accept  = (state_q == POOL_RUN) && in_valid;
    assign lb_we   = accept && in_pool && c_q[0] && !r_q[0];
    assign lb_addr = LB_AW'(c_q >> 1);

    assign x        = $signed(in_data);
    assign pair     = smax(hmax_q, x);
    assign lb_rd    = $signed(lb_rd_raw);
    assign pool_max = smax(lb_rd, pair);
    assign res      = (APPLY_RELU != 0) ? relu(pool_max) : pool_max;
    assign addr_now = ADDR_W'(int'(ch_q) * PLANE + int'(r_q >> 1) * OUT_W + int'(c_q >> 1));

    pool_line_buffer #(
        .DEPTH (LB_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_line_buf (
        .clk_i     (clk),
        .wr_en_i   (lb_we),
        .wr_addr_i (lb_addr),
        .wr_data_i (pair),
        .rd_addr_i (lb_addr),
        .rd_data_o (lb_rd_raw)
    );

    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        r_d         = r_q;
        ch_d        = ch_q;
        hmax_d      = hmax_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        busy_d      = busy_q;
        done_d      = done_q;
        case (state_q)
            POOL_IDLE: begin
                if (start) begin
                    state_d = POOL_RUN;
                    c_d     = '0;
                    r_d     = '0;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            POOL_RUN: begin
                if (in_valid) begin
                    if (in_pool && !c_q[0]) begin
                        hmax_d = x;
                    end
                    if (in_pool && c_q[0] && r_q[0]) begin
                        out_valid_d = 1'b1;
                        out_data_d  = res;
                        out_addr_d  = addr_now;
                    end
                    if (last_c) begin
                        c_d = '0;
                        if (last_r) begin
                            r_d = '0;
                            if (last_ch) begin
                                ch_d    = '0;
                                state_d = POOL_DONE;
                                busy_d  = 1'b0;
                            end else begin
                                ch_d = ch_q + CHW'(1);
                            end
                        end else begin
                            r_d = r_q + RW'(1);
                        end
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end
            end
            POOL_DONE: begin
                state_d = POOL_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = POOL_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= POOL_IDLE;
            c_q         <= '0;
            r_q         <= '0;
            ch_q        <= '0;
            hmax_q      <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            r_q         <= r_d;
            ch_q        <= ch_d;
            hmax_q      <= hmax_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign pool_done = done_q;

endmodule

// File: tb/tb_maxpool2d.sv
// tb/tb_maxpool2d.sv - randomized self-checking bench for maxpool2d against an array-based pooling model
module tb_maxpool2d;

    localparam int NDUT = 3;
    localparam int GW[NDUT] = '{4, 4, 5};
    localparam int GH[NDUT] = '{4, 4, 5};
    localparam int GC[NDUT] = '{1, 1, 2};
    localparam int GR[NDUT] = '{1, 0, 1};
    localparam int MON_MAX  = 512;

    logic clk = 1'b0;
    logic rst;
    logic        start_v    [NDUT];
    logic        in_valid_v [NDUT];
    logic [15:0] in_data_v  [NDUT];
    wire  [NDUT-1:0] ov_w;
    wire  [NDUT-1:0] busy_w;
    wire  [NDUT-1:0] done_w;
    wire  [15:0] od_w [NDUT];
    wire  [7:0]  oa_w [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int AN = (GW[g] / 2) * (GH[g] / 2) * GC[g];
        localparam int AW = (AN > 1) ? $clog2(AN) : 1;
        wire [AW-1:0] addr;
        maxpool2d #(
            .IN_WIDTH     (GW[g]),
            .IN_HEIGHT    (GH[g]),
            .NUM_CHANNELS (GC[g]),
            .DATA_WIDTH   (16),
            .APPLY_RELU   (GR[g])
        ) u_dut (
            .clk       (clk),
            .reset     (rst),
            .start     (start_v[g]),
            .in_data   (in_data_v[g]),
            .in_valid  (in_valid_v[g]),
            .out_data  (od_w[g]),
            .out_addr  (addr),
            .out_valid (ov_w[g]),
            .busy      (busy_w[g]),
            .pool_done (done_w[g])
        );
        assign oa_w[g] = 8'(addr);
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int mon_tot  [NDUT];
    int mon_addr [NDUT][MON_MAX];
    int mon_data [NDUT][MON_MAX];
    int mon_cyc  [NDUT][MON_MAX];

    int smp     [64];
    int pres    [64];
    int exp_addr[64];
    int exp_data[64];
    int exp_idx [64];
    int exp_n;

    always @(posedge clk) cyc <= cyc + 1;

    initial for (int k = 0; k < NDUT; k++) mon_tot[k] = 0;

    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (ov_w[k] === 1'b1) begin
                if (mon_tot[k] < MON_MAX) begin
                    mon_addr[k][mon_tot[k]] = int'(oa_w[k]);
                    mon_data[k][mon_tot[k]] = int'($signed(od_w[k]));
                    mon_cyc[k][mon_tot[k]]  = cyc;
                end
                mon_tot[k] = mon_tot[k] + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Pool each 2x2 window of the feature maps held in smp[]; odd trailing row/column is never visited.
    task automatic build_expected(input int g);
        int w, h, ow, oh, m, v, k;
        w = GW[g]; h = GH[g]; ow = w / 2; oh = h / 2; k = 0;
        for (int ch = 0; ch < GC[g]; ch++)
            for (int oy = 0; oy < oh; oy++)
                for (int ox = 0; ox < ow; ox++) begin
                    m = -100000;
                    for (int dy = 0; dy < 2; dy++)
                        for (int dx = 0; dx < 2; dx++) begin
                            v = smp[ch * h * w + (2 * oy + dy) * w + 2 * ox + dx];
                            if (v > m) m = v;
                        end
                    if (GR[g] != 0 && m < 0) m = 0;
                    exp_addr[k] = ch * oh * ow + oy * ow + ox;
                    exp_data[k] = m;
                    exp_idx[k]  = ch * h * w + (2 * oy + 1) * w + 2 * ox + 1;
                    k++;
                end
        exp_n = k;
    endtask

    task automatic fill(input int g, input int mode);
        logic signed [15:0] t;
        for (int i = 0; i < GW[g] * GH[g] * GC[g]; i++) begin
            case (mode)
                0:       smp[i] = (i + 1) * 256;
                1:       smp[i] = -(i + 1) * 256;
                default: begin t = 16'($urandom); smp[i] = int'(t); end
            endcase
        end
    endtask

    task automatic pulse_start(input int g);
        @(posedge clk); #1;
        start_v[g] = 1'b1;
        @(posedge clk); #1;
        start_v[g] = 1'b0;
    endtask

    task automatic run_pass(input int g, input int gap_pct, input bit poke_start);
        int n, base;
        n = GW[g] * GH[g] * GC[g];
        base = mon_tot[g];
        build_expected(g);
        pulse_start(g);
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                in_valid_v[g] = 1'b0;
                start_v[g] = poke_start;
                @(posedge clk); #1;
                start_v[g] = 1'b0;
            end
            in_valid_v[g] = 1'b1;
            in_data_v[g]  = 16'(smp[i]);
            pres[i] = cyc;
            if (poke_start && i == 2) start_v[g] = 1'b1;
            if (i == 1) check_eq($sformatf("busy_run[%0d]", g), int'(busy_w[g]), 1);
            @(posedge clk); #1;
            start_v[g] = 1'b0;
        end
        in_valid_v[g] = 1'b0;
        check_eq($sformatf("done_early[%0d]", g), int'(done_w[g]), 0);
        start_v[g] = poke_start;
        @(posedge clk); #1;
        start_v[g] = 1'b0;
        check_eq($sformatf("pool_done[%0d]", g), int'(done_w[g]), 1);
        check_eq($sformatf("busy_end[%0d]", g), int'(busy_w[g]), 0);
        check_eq($sformatf("n_out[%0d]", g), mon_tot[g] - base, exp_n);
        for (int k = 0; k < exp_n && base + k < mon_tot[g] && base + k < MON_MAX; k++) begin
            check_eq($sformatf("addr[%0d][%0d]", g, k), mon_addr[g][base + k], exp_addr[k]);
            check_eq($sformatf("data[%0d][%0d]", g, k), mon_data[g][base + k], exp_data[k]);
            check_eq($sformatf("lat[%0d][%0d]", g, k), mon_cyc[g][base + k], pres[exp_idx[k]] + 1);
        end
    endtask

    task automatic abort_pass(input int g, input int after);
        int base;
        fill(g, 0);
        build_expected(g);
        pulse_start(g);
        for (int i = 0; i < after; i++) begin
            in_valid_v[g] = 1'b1;
            in_data_v[g]  = 16'(smp[i]);
            @(posedge clk); #1;
        end
        in_valid_v[g] = 1'b0;
        check_eq("pre_rst_data", int'($signed(od_w[g])), exp_data[0]);
        base = mon_tot[g];
        rst = 1'b1;
        #1;
        check_eq("rst_valid", int'(ov_w[g]), 0);
        check_eq("rst_data", int'(od_w[g]), 0);
        check_eq("rst_addr", int'(oa_w[g]), 0);
        check_eq("rst_busy", int'(busy_w[g]), 0);
        check_eq("rst_done", int'(done_w[g]), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid_v[g] = 1'b1;
            in_data_v[g]  = 16'($urandom);
            @(posedge clk); #1;
        end
        in_valid_v[g] = 1'b0;
        check_eq("idle_no_out", mon_tot[g] - base, 0);
        check_eq("idle_busy", int'(busy_w[g]), 0);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            start_v[k] = 1'b0; in_valid_v[k] = 1'b0; in_data_v[k] = '0;
        end
        #3;
        for (int k = 0; k < NDUT; k++) begin
            check_eq($sformatf("reset_valid[%0d]", k), int'(ov_w[k]), 0);
            check_eq($sformatf("reset_data[%0d]", k), int'(od_w[k]), 0);
            check_eq($sformatf("reset_addr[%0d]", k), int'(oa_w[k]), 0);
            check_eq($sformatf("reset_busy[%0d]", k), int'(busy_w[k]), 0);
            check_eq($sformatf("reset_done[%0d]", k), int'(done_w[k]), 0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        fill(0, 0); run_pass(0, 0, 1'b0);
        fill(0, 1); run_pass(0, 0, 1'b0);
        fill(1, 1); run_pass(1, 0, 1'b0);
        fill(1, 0); run_pass(1, 0, 1'b0);
        fill(2, 0); run_pass(2, 0, 1'b0);
        run_pass(2, 30, 1'b1);

        abort_pass(0, 7);
        fill(0, 2); run_pass(0, 0, 1'b0);

        for (int rep = 0; rep < 4; rep++)
            for (int g = 0; g < NDUT; g++) begin
                fill(g, 2);
                run_pass(g, rep * 10, rep[0]);
            end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
